// File: rtl/ad_pkg.sv
// Shared definitions for the ADC sample path: word tags, default widths and
// the frame unpacker state encoding.
package ad_pkg;

  localparam int TAG_W     = 2;
  localparam int AD_DATA_W = 16;
  localparam int AD_NUM_CH = 6;
  localparam int AD_WORD_W = AD_DATA_W + TAG_W;

  localparam logic [TAG_W-1:0] TAG_SOF = 2'b01;
  localparam logic [TAG_W-1:0] TAG_MID = 2'b00;
  localparam logic [TAG_W-1:0] TAG_EOF = 2'b10;

  // One-hot unpacker states
  typedef enum logic [2:0] {
    ST_HUNT    = 3'b001,
    ST_COLLECT = 3'b010,
    ST_HOLD    = 3'b100
  } ad_state_e;

endpackage

// File: rtl/ad_sat_cnt.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module ad_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on inc unless already at the maximum value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                          count <= '0;
    else if (inc && (count != {W{1'b1}})) count <= count + W'(1);
  end

endmodule

// File: rtl/ad_frame_unpack.sv
// Reader side of the ADC sample FIFO. Pops tagged words one at a time,
// aligns them into NUM_CH-channel frames and presents each complete frame
// with a valid/ready handshake. Framing errors are counted and force a
// resynchronisation on the next SOF.
module ad_frame_unpack
  import ad_pkg::*;
#(
  parameter int NUM_CH = AD_NUM_CH,
  parameter int DATA_W = AD_DATA_W,
  parameter int ERR_W  = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     fifo_empty,
  output logic                     fifo_rden,
  input  logic [DATA_W+TAG_W-1:0]  fifo_rdata,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic [NUM_CH*DATA_W-1:0] frame_data,
  output logic [ERR_W-1:0]         frame_err_cnt,
  output logic                     sync_lost
);

  localparam int                IDX_W    = $clog2(NUM_CH);
  localparam int                WORD_W   = DATA_W + TAG_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CH - 1);

  ad_state_e                       state, state_d;
  logic                            rd_pend;
  logic [IDX_W-1:0]                idx, idx_d;

  // ch1..ch(N-1) are staged here; the last channel goes straight from the
  // FIFO word into the output register, so partial data never reaches
  // frame_data.
  logic [NUM_CH-2:0][DATA_W-1:0]   ch_q;
  logic [NUM_CH-1:0][DATA_W-1:0]   frame_q;

  logic [TAG_W-1:0]                tag;
  logic [DATA_W-1:0]               sample;
  logic                            cap;
  logic                            err;
  logic                            ch_we;
  logic [IDX_W-1:0]                ch_sel;
  logic                            load;

  assign tag    = fifo_rdata[WORD_W-1 -: TAG_W];
  assign sample = fifo_rdata[DATA_W-1:0];
  assign cap    = rd_pend;

  // Single outstanding read; no pops while a frame waits downstream.
  assign fifo_rden   = resetn && !fifo_empty && !rd_pend && (state != ST_HOLD);
  assign frame_valid = (state == ST_HOLD);
  assign frame_data  = frame_q;

  // State, slot index and read-in-flight registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_HUNT;
      idx     <= '0;
      rd_pend <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      rd_pend <= fifo_rden;
    end
  end

  // Next-state decode: acts only on a captured word, except HOLD which
  // waits for the downstream handshake.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    err     = 1'b0;
    ch_we   = 1'b0;
    ch_sel  = '0;
    load    = 1'b0;
    case (state)
      ST_HUNT: begin
        if (cap) begin
          if (tag == TAG_SOF) begin
            ch_we   = 1'b1;
            idx_d   = IDX_W'(1);
            state_d = ST_COLLECT;
          end else begin
            err     = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (cap) begin
          if (tag == TAG_SOF) begin
            // restart the frame on the new SOF, still an error
            ch_we   = 1'b1;
            idx_d   = IDX_W'(1);
            err     = 1'b1;
          end else if (tag == TAG_MID && idx < LAST_IDX) begin
            ch_we   = 1'b1;
            ch_sel  = idx;
            idx_d   = idx + IDX_W'(1);
          end else if (tag == TAG_EOF && idx == LAST_IDX) begin
            load    = 1'b1;
            idx_d   = '0;
            state_d = ST_HOLD;
          end else begin
            err     = 1'b1;
            idx_d   = '0;
            state_d = ST_HUNT;
          end
        end
      end
      ST_HOLD: begin
        if (frame_ready) state_d = ST_HUNT;
      end
      default: begin
        state_d = ST_HUNT;
        idx_d   = '0;
      end
    endcase
  end

  // Channel staging registers, written one slot per captured word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ch_q <= '0;
    end else if (ch_we) begin
      for (int i = 0; i < NUM_CH - 1; i++)
        if (ch_sel == IDX_W'(i)) ch_q[i] <= sample;
    end
  end

  // Output frame register, loaded only when the EOF completes a frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_q <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_CH - 1; i++) frame_q[i] <= ch_q[i];
      frame_q[NUM_CH-1] <= sample;
    end
  end

  // One-cycle pulse following each framing error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_lost <= 1'b0;
    else         sync_lost <= err;
  end

  ad_sat_cnt #(.W(ERR_W)) u_err_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (err),
    .count  (frame_err_cnt)
  );

endmodule

// File: tb/tb_ad_frame_unpack.sv
// Bench for ad_frame_unpack: a FIFO model feeds tagged words, a stream-level
// reference model predicts frames and error counts, and a monitor process
// checks every handshake and protocol property against those predictions.
module tb_ad_frame_unpack;

  localparam int NCH = 6;
  localparam int DW  = 16;
  localparam int EW  = 4;
  localparam int FW  = NCH * DW;
  localparam int SAT = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rden;
  logic [DW+1:0] fifo_rdata = '0;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [FW-1:0] frame_data;
  logic [EW-1:0] frame_err_cnt;
  logic          sync_lost;

  ad_frame_unpack #(.NUM_CH(NCH), .DATA_W(DW), .ERR_W(EW)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .fifo_empty    (fifo_empty),
    .fifo_rden     (fifo_rden),
    .fifo_rdata    (fifo_rdata),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_data    (frame_data),
    .frame_err_cnt (frame_err_cnt),
    .sync_lost     (sync_lost)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW+1:0] fq[$];
  logic [FW-1:0] exp_q[$];
  logic [DW-1:0] part[$];
  int            m_err = 0;
  int            sync_cnt = 0;
  int            sync_base = 0;
  int            frames_seen = 0;
  int            ready_mode = 1;
  bit            stall_en = 1'b0;
  bit            fake_avail = 1'b0;
  logic [FW-1:0] last_frame = '0;

  function automatic void chk(bit ok, string nm, logic [FW-1:0] act, logic [FW-1:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endfunction

  // Reference model over the word stream: a frame is SOF, NCH-2 MIDs, EOF.
  task automatic model_word(input logic [DW+1:0] w);
    logic [1:0]    t;
    logic [FW-1:0] f;
    t = w[DW+1:DW];
    if (t == 2'b01) begin
      if (part.size() != 0) m_err++;
      part.delete();
      part.push_back(w[DW-1:0]);
    end else if (part.size() == 0) begin
      m_err++;
    end else if (t == 2'b00 && part.size() < NCH - 1) begin
      part.push_back(w[DW-1:0]);
    end else if (t == 2'b10 && part.size() == NCH - 1) begin
      part.push_back(w[DW-1:0]);
      f = '0;
      for (int i = 0; i < NCH; i++) f[i*DW +: DW] = part[i];
      exp_q.push_back(f);
      part.delete();
    end else begin
      m_err++;
      part.delete();
    end
  endtask

  task automatic push(input logic [DW+1:0] w);
    fq.push_back(w);
    model_word(w);
  endtask

  task automatic push_frame();
    push({2'b01, 16'($urandom)});
    for (int k = 1; k < NCH - 1; k++) push({2'b00, 16'($urandom)});
    push({2'b10, 16'($urandom)});
  endtask

  function automatic logic [DW+1:0] garbage();
    int t;
    t = $urandom_range(0, 2);
    return {(t == 0) ? 2'b00 : (t == 1) ? 2'b10 : 2'b11, 16'($urandom)};
  endfunction

  // FIFO model: word appears on fifo_rdata the cycle after the pop
  always @(posedge clk) begin
    if (fifo_rden && fq.size() > 0) fifo_rdata <= fq.pop_front();
  end

  always @(posedge clk) begin
    #2;
    fifo_empty = !fake_avail && ((fq.size() == 0) || (stall_en && $urandom_range(0, 2) == 0));
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       frame_ready = 1'b0;
      1:       frame_ready = 1'b1;
      default: frame_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: handshakes, hold stability, read protocol, error pulses
  logic          prev_valid = 1'b0, prev_acc = 1'b0, prev_rden = 1'b0, prev_sync = 1'b0;
  logic [FW-1:0] prev_data = '0;
  logic [FW-1:0] mon_e;
  always @(negedge clk) begin
    if (resetn) begin
      if (sync_lost) begin
        sync_cnt++;
        chk(!prev_sync, "sync_lost_width", {31'd0, prev_sync}, 0);
      end
      if (fifo_rden) begin
        chk(!prev_rden, "rden_back_to_back", {31'd0, prev_rden}, 0);
        chk(!frame_valid, "rden_in_hold", {31'd0, frame_valid}, 0);
        chk(!fifo_empty, "rden_when_empty", {31'd0, fifo_empty}, 0);
      end
      if (prev_valid && !prev_acc)
        chk(frame_valid && frame_data == prev_data, "hold_stable", frame_data, prev_data);
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_frame", frame_data, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk(frame_data == mon_e, "frame_data", frame_data, mon_e);
        end
        last_frame = frame_data;
        frames_seen++;
      end
      prev_valid = frame_valid;
      prev_acc   = frame_valid && frame_ready;
      prev_rden  = fifo_rden;
      prev_sync  = sync_lost;
      prev_data  = frame_data;
    end else begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      prev_rden  = 1'b0;
      prev_sync  = 1'b0;
    end
  end

  task automatic wait_drain(input string nm);
    int idle;
    idle = 0;
    for (int c = 0; c < 4000 && idle < 8; c++) begin
      @(posedge clk);
      if (fq.size() == 0 && exp_q.size() == 0) idle++;
      else idle = 0;
    end
    if (idle < 8) chk(1'b0, {"drain_timeout_", nm}, exp_q.size(), 0);
  endtask

  task automatic check_counts(input string nm);
    int e;
    e = (m_err > SAT) ? SAT : m_err;
    chk(frame_err_cnt == EW'(e), {"err_cnt_", nm}, frame_err_cnt, e);
    chk(sync_cnt - sync_base == m_err, {"sync_pulses_", nm}, sync_cnt - sync_base, m_err);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    resetn     = 1'b0;
    fake_avail = 1'b1;
    fifo_empty = 1'b0;
    #1;
    chk(!frame_valid, {"rst_valid_", nm}, frame_valid, 0);
    chk(frame_data == '0, {"rst_data_", nm}, frame_data, 0);
    chk(frame_err_cnt == '0, {"rst_errcnt_", nm}, frame_err_cnt, 0);
    chk(!sync_lost, {"rst_sync_", nm}, sync_lost, 0);
    chk(!fifo_rden, {"rst_rden_", nm}, fifo_rden, 0);
    fq.delete();
    part.delete();
    exp_q.delete();
    m_err      = 0;
    fake_avail = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    sync_base = sync_cnt;
    resetn    = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [FW-1:0] ref_clean;
    logic [FW-1:0] held;
    int            f0;
    bit            seen;
    ref_clean = 96'h0006_0005_0004_0003_0002_0001;

    do_reset("init");

    // Clean frame
    ready_mode = 1;
    f0 = frames_seen;
    push(18'h1_0001); push(18'h0_0002); push(18'h0_0003);
    push(18'h0_0004); push(18'h0_0005); push(18'h2_0006);
    wait_drain("clean");
    chk(last_frame == ref_clean, "clean_value", last_frame, ref_clean);
    chk(frames_seen - f0 == 1, "clean_count", frames_seen - f0, 1);
    check_counts("clean");

    // Backpressure with two queued frames
    ready_mode = 0;
    @(posedge clk);
    push_frame();
    push_frame();
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = frame_valid;
    end
    chk(seen, "bp_valid_rises", {31'd0, seen}, 1);
    repeat (20) @(negedge clk);
    held = exp_q[0];
    chk(frame_valid && frame_data == held, "bp_held_frame", frame_data, held);
    chk(fq.size() == NCH, "bp_no_reads", fq.size(), NCH);
    ready_mode = 1;
    wait_drain("bp");
    check_counts("bp");

    // Leading garbage
    do_reset("garbage");
    push(18'h0_1111);
    push(18'h2_2222);
    push_frame();
    wait_drain("garbage");
    chk(frame_err_cnt == 2, "garbage_cnt2", frame_err_cnt, 2);
    check_counts("garbage");

    // SOF in the middle of a frame
    do_reset("sofmid");
    push(18'h1_A001); push(18'h0_A002); push(18'h0_A003);
    push(18'h1_B001);
    for (int k = 2; k < NCH; k++) push({2'b00, 16'hB000 + 16'(k)});
    push(18'h2_B006);
    wait_drain("sofmid");
    chk(last_frame[DW-1:0] == 16'hB001, "sofmid_ch1", last_frame[DW-1:0], 16'hB001);
    check_counts("sofmid");

    // Early EOF, then tag 11 inside a frame
    do_reset("early");
    f0 = frames_seen;
    push(18'h1_0101); push(18'h0_0102); push(18'h2_0103);
    push(18'h1_0201); push(18'h0_0202); push(18'h3_0203);
    push_frame();
    wait_drain("early");
    chk(frames_seen - f0 == 1, "early_frames", frames_seen - f0, 1);
    check_counts("early");

    // Saturation, then reset while collecting
    do_reset("sat");
    for (int k = 0; k < 20; k++) push(garbage());
    wait_drain("sat");
    chk(frame_err_cnt == SAT, "sat_value", frame_err_cnt, SAT);
    check_counts("sat");
    push(18'h1_0301); push(18'h0_0302); push(18'h0_0303);
    wait_drain("partial");
    do_reset("midcollect");
    f0 = frames_seen;
    push_frame();
    wait_drain("after_rst");
    chk(frames_seen - f0 == 1, "after_rst_frames", frames_seen - f0, 1);
    check_counts("after_rst");

    // Randomised mix with stalls and random backpressure
    do_reset("rand");
    ready_mode = 2;
    stall_en   = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 6) begin
        push_frame();
      end else begin
        for (int k = 0, m = $urandom_range(1, 4); k < m; k++) begin
          if ($urandom_range(0, 3) == 0) push({2'b01, 16'($urandom)});
          else push(garbage());
        end
      end
    end
    wait_drain("rand");
    check_counts("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
